// File: rtl/load_use_scoreboard.sv
// -----------------------------------------------------------------------------
// load_use_scoreboard
//
// Load-use hazard unit for the pipelined RISC-V core. It sits beside the ID
// stage and remembers which loads left ID/EX during the last LOAD_LAT-1 cycles,
// because their results are not forwardable yet. While the instruction in
// IF/ID reads one of those destinations, the unit stalls the PC and IF/ID and
// injects a bubble into ID/EX. A taken branch (flush) always wins over a stall.
//
// Optional feature macro: HAZARD_STATS_EN
//   defined   -> stall_total / load_total are saturating statistics counters
//   undefined -> both outputs are tied to zero and no counter flops exist
//
// Parameters
//   REG_ADDR_W  register-index width
//   LOAD_LAT    cycles from a load leaving ID/EX until its result is
//               forwardable (>=1, 1 = classic load-use, max 8 for pending_cnt)
//   CNT_W       statistics counter width
//
// Ports
//   clk             core clock, all state on the rising edge
//   rst             synchronous reset, active-low (0 = reset)
//   if_id_valid     IF/ID holds a live instruction
//   if_id_rs1/rs2   IF/ID source registers
//   if_id_use_rs1/2 instruction actually reads rs1 / rs2
//   id_ex_valid     ID/EX holds a live instruction
//   id_ex_mem_read  ID/EX instruction is a load
//   id_ex_rd        ID/EX destination register
//   flush           taken branch/jump kills IF/ID this cycle
//   stall           hazard stall request (combinational)
//   pc_write        PC write enable
//   if_id_write     IF/ID write enable
//   id_ex_bubble    zero the ID/EX controls on the next edge
//   pending_cnt     number of valid pending loads, registered
//   stall_total     stall cycles since reset
//   load_total      loads tracked since reset
// -----------------------------------------------------------------------------
module load_use_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 2,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_id_valid,
  input  logic [REG_ADDR_W-1:0] if_id_rs1,
  input  logic [REG_ADDR_W-1:0] if_id_rs2,
  input  logic                  if_id_use_rs1,
  input  logic                  if_id_use_rs2,
  input  logic                  id_ex_valid,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  flush,
  output logic                  stall,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_bubble,
  output logic [2:0]            pending_cnt,
  output logic [CNT_W-1:0]      stall_total,
  output logic [CNT_W-1:0]      load_total
);

  // A load writing x0 is never tracked: x0 cannot carry a dependency.
  logic loadInEx;
  logic pendHit1;
  logic pendHit2;
  logic match1;
  logic match2;
  logic hazard;

  assign loadInEx = id_ex_valid & id_ex_mem_read & (id_ex_rd != '0);

  generate
    if (LOAD_LAT > 1) begin : gPend
      localparam int DEPTH = LOAD_LAT - 1;

      // Entry k holds the load that left ID/EX k+1 edges ago. No back-pressure:
      // the shift happens every cycle and the oldest entry simply falls off.
      logic [DEPTH-1:0]      pendV;
      logic [REG_ADDR_W-1:0] pendRd [DEPTH];
      logic [DEPTH-1:0]      nextV;
      logic [2:0]            nextCnt;

      always_comb begin
        nextV    = '0;
        nextV[0] = loadInEx;
        for (int k = 1; k < DEPTH; k++) begin
          nextV[k] = pendV[k-1];
        end
        nextCnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
          nextCnt = nextCnt + {2'b00, nextV[k]};
        end
      end

      always_comb begin
        pendHit1 = 1'b0;
        pendHit2 = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
          if (pendV[k] && (pendRd[k] == if_id_rs1)) pendHit1 = 1'b1;
          if (pendV[k] && (pendRd[k] == if_id_rs2)) pendHit2 = 1'b1;
        end
      end

      // Flush deliberately leaves the array alone: loads already past ID/EX
      // are older than the branch and still write back.
      always_ff @(posedge clk) begin
        if (!rst) begin
          pendV       <= '0;
          pending_cnt <= '0;
        end else begin
          pendV       <= nextV;
          pending_cnt <= nextCnt;
        end
        pendRd[0] <= id_ex_rd;
        for (int k = 1; k < DEPTH; k++) begin
          pendRd[k] <= pendRd[k-1];
        end
      end
    end else begin : gNoPend
      assign pendHit1    = 1'b0;
      assign pendHit2    = 1'b0;
      assign pending_cnt = '0;
    end
  endgenerate

  // The load still sitting in ID/EX counts as well; that is the classic
  // one-cycle load-use case.
  assign match1 = (if_id_rs1 != '0) & ((loadInEx & (id_ex_rd == if_id_rs1)) | pendHit1);
  assign match2 = (if_id_rs2 != '0) & ((loadInEx & (id_ex_rd == if_id_rs2)) | pendHit2);
  assign hazard = if_id_valid & ((if_id_use_rs1 & match1) | (if_id_use_rs2 & match2));

  // During reset the pipeline is frozen and ID/EX is kept empty.
  assign stall        = rst & hazard & ~flush;
  assign pc_write     = rst & ~stall;
  assign if_id_write  = rst & ~stall;
  assign id_ex_bubble = ~rst | stall | flush;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_total <= '0;
      load_total  <= '0;
    end else begin
      if (stall && (stall_total != '1)) stall_total <= stall_total + CNT_W'(1);
      if (loadInEx && (load_total != '1)) load_total <= load_total + CNT_W'(1);
    end
  end
`else
  assign stall_total = '0;
  assign load_total  = '0;
`endif

endmodule

// File: tb/tb_load_use_scoreboard.sv
module tb_load_use_scoreboard;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       if_id_valid, if_id_use_rs1, if_id_use_rs2;
  logic       id_ex_valid, id_ex_mem_read, flush;
  logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;

  // Three instances on the same stimulus: LOAD_LAT = 2, 1, 3.
  logic        stall_o       [3];
  logic        pc_write_o    [3];
  logic        if_id_write_o [3];
  logic        id_ex_bubble_o[3];
  logic [2:0]  pending_o     [3];
  logic [31:0] stall_total_o [3];
  logic [31:0] load_total_o  [3];

  load_use_scoreboard #(.REG_ADDR_W(5), .LOAD_LAT(2), .CNT_W(32)) dut_lat2 (
    .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2), .id_ex_valid(id_ex_valid),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd), .flush(flush),
    .stall(stall_o[0]), .pc_write(pc_write_o[0]), .if_id_write(if_id_write_o[0]),
    .id_ex_bubble(id_ex_bubble_o[0]), .pending_cnt(pending_o[0]),
    .stall_total(stall_total_o[0]), .load_total(load_total_o[0]));

  load_use_scoreboard #(.REG_ADDR_W(5), .LOAD_LAT(1), .CNT_W(32)) dut_lat1 (
    .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2), .id_ex_valid(id_ex_valid),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd), .flush(flush),
    .stall(stall_o[1]), .pc_write(pc_write_o[1]), .if_id_write(if_id_write_o[1]),
    .id_ex_bubble(id_ex_bubble_o[1]), .pending_cnt(pending_o[1]),
    .stall_total(stall_total_o[1]), .load_total(load_total_o[1]));

  load_use_scoreboard #(.REG_ADDR_W(5), .LOAD_LAT(3), .CNT_W(32)) dut_lat3 (
    .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2), .id_ex_valid(id_ex_valid),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd), .flush(flush),
    .stall(stall_o[2]), .pc_write(pc_write_o[2]), .if_id_write(if_id_write_o[2]),
    .id_ex_bubble(id_ex_bubble_o[2]), .pending_cnt(pending_o[2]),
    .stall_total(stall_total_o[2]), .load_total(load_total_o[2]));

  // ---------------- reference model ----------------
  // load_hist[j] = destination of the tracked load that left ID/EX j+1 edges
  // ago (0 = none). A source waits on it while j+1 < LOAD_LAT.
  logic [4:0]  load_hist [8];
  logic [31:0] stall_cnt_m [3];
  logic [31:0] load_cnt_m  [3];
  logic        exp_stall_m [3];
  int          run_len [3];

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  function automatic int lat_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic logic cur_load();
    return id_ex_valid && id_ex_mem_read && (id_ex_rd != 5'd0);
  endfunction

  function automatic logic model_match(input int lat, input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (cur_load() && (id_ex_rd == r)) return 1'b1;
    for (int j = 0; j < lat - 1; j++) begin
      if (load_hist[j] == r) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic clear_model();
    for (int j = 0; j < 8; j++) load_hist[j] = 5'd0;
    for (int i = 0; i < 3; i++) begin
      stall_cnt_m[i] = 32'd0;
      load_cnt_m[i]  = 32'd0;
      exp_stall_m[i] = 1'b0;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      int         lat;
      logic       hz, es, epc, eb;
      logic [2:0] pend;
      lat = lat_of(i);
      hz  = if_id_valid && ((if_id_use_rs1 && model_match(lat, if_id_rs1)) ||
                            (if_id_use_rs2 && model_match(lat, if_id_rs2)));
      if (!rst) begin
        es = 1'b0; epc = 1'b0; eb = 1'b1;
      end else begin
        es = hz && !flush; epc = !es; eb = es || flush;
      end
      exp_stall_m[i] = es;
      pend = 3'd0;
      for (int j = 0; j < lat - 1; j++) if (load_hist[j] != 5'd0) pend++;
      check($sformatf("stall_L%0d", lat),        32'(stall_o[i]),        32'(es));
      check($sformatf("pc_write_L%0d", lat),     32'(pc_write_o[i]),     32'(epc));
      check($sformatf("if_id_write_L%0d", lat),  32'(if_id_write_o[i]),  32'(epc));
      check($sformatf("id_ex_bubble_L%0d", lat), 32'(id_ex_bubble_o[i]), 32'(eb));
      check($sformatf("pending_cnt_L%0d", lat),  32'(pending_o[i]),      32'(pend));
`ifdef HAZARD_STATS_EN
      check($sformatf("stall_total_L%0d", lat), stall_total_o[i], stall_cnt_m[i]);
      check($sformatf("load_total_L%0d", lat),  load_total_o[i],  load_cnt_m[i]);
`else
      check($sformatf("stall_total_L%0d", lat), stall_total_o[i], 32'd0);
      check($sformatf("load_total_L%0d", lat),  load_total_o[i],  32'd0);
`endif
      if (stall_o[i] === 1'b1) run_len[i]++;
    end
  endtask

  // Advance the model with the inputs that were present at the edge.
  task automatic update_model();
    if (!rst) begin
      clear_model();
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (exp_stall_m[i] && (stall_cnt_m[i] != 32'hffff_ffff)) stall_cnt_m[i]++;
        if (cur_load() && (load_cnt_m[i] != 32'hffff_ffff)) load_cnt_m[i]++;
      end
      for (int j = 7; j > 0; j--) load_hist[j] = load_hist[j-1];
      load_hist[0] = cur_load() ? id_ex_rd : 5'd0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic ev, input logic emr,
                      input logic [4:0] erd, input logic fl);
    rst = r; if_id_valid = iv; if_id_rs1 = rs1; if_id_rs2 = rs2;
    if_id_use_rs1 = u1; if_id_use_rs2 = u2;
    id_ex_valid = ev; id_ex_mem_read = emr; id_ex_rd = erd; flush = fl;
    #4;
    check_all();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic start_run();
    for (int i = 0; i < 3; i++) run_len[i] = 0;
  endtask

  // Expected stall-run lengths for LOAD_LAT = 2, 1, 3.
  task automatic end_run(input string tag, input int e2, input int e1, input int e3);
    exp_q.push_back(32'(e2));
    exp_q.push_back(32'(e1));
    exp_q.push_back(32'(e3));
    for (int i = 0; i < 3; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      check($sformatf("%s_runlen_L%0d", tag, lat_of(i)), 32'(run_len[i]), e);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; if_id_valid = 1'b0; if_id_rs1 = 5'd0; if_id_rs2 = 5'd0;
    if_id_use_rs1 = 1'b0; if_id_use_rs2 = 1'b0; id_ex_valid = 1'b0;
    id_ex_mem_read = 1'b0; id_ex_rd = 5'd0; flush = 1'b0;
    clear_model();
    start_run();
    repeat (2) @(posedge clk);
    #1;

    // Reset state: hazard inputs present but outputs forced.
    step(0, 1, 5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 0);

    // Adjacent load-use: LOAD_LAT cycles of stall.
    start_run();
    step(1, 1, 5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 0);
    step(1, 1, 5'd5, 5'd0, 1, 0, 0, 0, 5'd0, 0);
    step(1, 1, 5'd5, 5'd0, 1, 0, 0, 0, 5'd0, 0);
    step(1, 1, 5'd5, 5'd0, 1, 0, 0, 0, 5'd0, 0);
    end_run("adjacent", 2, 1, 3);

    // One independent instruction between load and use.
    start_run();
    step(1, 1, 5'd1, 5'd2, 1, 1, 1, 1, 5'd5, 0);
    step(1, 1, 5'd5, 5'd0, 1, 0, 1, 0, 5'd7, 0);
    step(1, 1, 5'd5, 5'd0, 1, 0, 0, 0, 5'd0, 0);
    step(1, 1, 5'd5, 5'd0, 1, 0, 0, 0, 5'd0, 0);
    end_run("gap1", 1, 0, 2);

    // Two independent instructions.
    start_run();
    step(1, 1, 5'd1, 5'd2, 1, 1, 1, 1, 5'd5, 0);
    step(1, 1, 5'd1, 5'd2, 1, 1, 1, 0, 5'd7, 0);
    step(1, 1, 5'd5, 5'd0, 1, 0, 1, 0, 5'd8, 0);
    step(1, 1, 5'd5, 5'd0, 1, 0, 0, 0, 5'd0, 0);
    step(1, 1, 5'd5, 5'd0, 1, 0, 0, 0, 5'd0, 0);
    end_run("gap2", 0, 0, 1);

    // x0 load / x0 use, and an unused rs2 matching rd.
    start_run();
    step(1, 1, 5'd0, 5'd0, 1, 1, 1, 1, 5'd0, 0);
    step(1, 1, 5'd0, 5'd0, 1, 1, 0, 0, 5'd0, 0);
    check("x0_pending_L2", 32'(pending_o[0]), 32'd0);
    step(1, 1, 5'd9, 5'd5, 1, 0, 1, 1, 5'd5, 0);
    step(1, 1, 5'd9, 5'd5, 1, 0, 0, 0, 5'd0, 0);
    end_run("nouse", 0, 0, 0);

    // Hazard killed by flush; the load is still tracked.
    step(1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0);
    step(1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0);
    step(1, 1, 5'd6, 5'd0, 1, 0, 1, 1, 5'd6, 1);
    check("flush_pending_L2", 32'(pending_o[0]), 32'd1);
    step(1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0);

    // Reset in the middle of a stall.
    step(1, 1, 5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 0);
    step(0, 1, 5'd5, 5'd0, 1, 0, 0, 0, 5'd0, 0);
    check("rst_mid_pending_L2", 32'(pending_o[0]), 32'd0);
    step(1, 1, 5'd5, 5'd0, 1, 0, 0, 0, 5'd0, 0);

    // Back-to-back lw/use x3 right after reset; counters count one each.
    step(0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0);
    start_run();
    step(1, 1, 5'd3, 5'd0, 1, 0, 1, 1, 5'd3, 0);
    step(1, 1, 5'd3, 5'd0, 1, 0, 0, 0, 5'd0, 0);
`ifdef HAZARD_STATS_EN
    check("lat1_stall_total", stall_total_o[1], 32'd1);
    check("lat1_load_total",  load_total_o[1],  32'd1);
`endif
    step(1, 1, 5'd3, 5'd0, 1, 0, 0, 0, 5'd0, 0);
    step(1, 1, 5'd3, 5'd0, 1, 0, 0, 0, 5'd0, 0);
    end_run("lat1", 2, 1, 3);

    // Randomized traffic on a small register set to provoke matches.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
           5'($urandom_range(0, 3)), $urandom_range(0, 5) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
